dct_2d_sched: RTL and testbench
===============================

# dct_2d_sched

Scheduler that builds an 8x8 2D DCT from one shared 8-point 1D DCT core. It accepts 8x8 blocks one row per beat and issues each row through the core. Results are captured into a ping-pong transpose buffer, and the buffered columns are then re-issued through the same core. The resulting column coefficients are presented on a valid/ready output stream. It sits between the level-shift/block-reorder stage and the quantizer.

## Interface
Parameters
- W: 16; word width of every data element (row input, core in/out, output).
- CORE_LAT: 8; fixed core latency; word issued in cycle t appears on core_x_out in cycle t+CORE_LAT.
- FIFO_DEPTH: 16; output FIFO entries (one column per entry), must be >= CORE_LAT.

Ports
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input row valid.
- s_ready  out  1  input row accepted when s_valid && s_ready.
- s_data  in  8xW signed  one row, s_data[i] = column i of the current row.
- m_valid  out  1  output column valid.
- m_ready  in  1  output column consumed when m_valid && m_ready.
- m_data  out  8xW signed  m_data[i] = coefficient (vertical freq i, horizontal freq = beat index).
- m_last  out  1  high on the 8th (last) column beat of a block.
- core_x_in  out  8xW signed  word driven to the 1D core (0 when no issue).
- core_x_out  in  8xW signed  core result.
- busy  out  1  any buffer not EMPTY, any tag in flight, or FIFO not empty.

## Operation
- Transpose buffers B0/B1, each 8x8xW. Each buffer has a state: EMPTY -> FILLING -> WAIT_ROWS -> FULL -> DRAINING -> EMPTY.
- Write side: wr_sel selects the buffer that receives rows. Row r of a block is accepted only while buffer wr_sel is EMPTY or FILLING; the first accept moves EMPTY->FILLING. After the 8th accept: FILLING->WAIT_ROWS, and wr_sel toggles.
- Row result: write the core result for row r into buf[r][0..7]. Once 8 row results have landed: WAIT_ROWS->FULL.
- Read side: rd_sel selects the draining buffer. Column c is eligible when buffer rd_sel is FULL or DRAINING and fifo_count + cols_in_flight < FIFO_DEPTH.
- Column issue: core_x_in[k] = buf[k][c]. The first issue moves FULL->DRAINING. After the 8th issue: DRAINING->EMPTY and rd_sel toggles. The buffer data is read at issue time, so the buffer may be refilled immediately.
- Arbitration per cycle, at most one issue:
  - A column issue has fixed priority over a row issue.
  - s_ready = row-eligible && !column issue this cycle.
  - A row issue happens exactly on an s_valid && s_ready handshake.
- Tag line: a CORE_LAT-deep shift register carrying {valid, kind(row/col), buf id, index 0..7, last}. Its output aligns with core_x_out. Row tags write the buffer; column tags push {core_x_out, last} into the FIFO.
- Arithmetic: no arithmetic inside this block; words pass unmodified at width W and the core owns scaling and rounding.
- Sustained throughput: 16 core slots per block, i.e. one block per 16 cycles.

## Timing
- Reset values:
  - m_valid=0, m_last=0, m_data=0, core_x_in=0, busy=0.
  - Both buffers EMPTY, wr_sel=rd_sel=B0, tags invalid, FIFO empty.
  - s_ready=1 one cycle after reset release, given s_ready is combinational from state.
- Buffer write: happens at the end of cycle t+CORE_LAT. FULL is visible in the following cycle.
- FIFO: push at the end of the tag-output cycle. m_valid rises the next cycle. First-word fall-through; m_data/m_last are stable while m_valid && !m_ready.
- Isolated block, m_ready=1: first row accepted in cycle 0 gives first m_valid in cycle 2*CORE_LAT+9 (25 at defaults), with 8 consecutive beats.
- FIFO credit counts in-flight columns, so a push can never overflow. A pop and a push in the same cycle are both honoured.
- Both buffers non-EMPTY/non-FILLING: s_ready=0 until wr_sel buffer returns to EMPTY.
- Reset mid-operation: all state is cleared asynchronously. In-flight core results after reset release are ignored because their tags are invalid, so no stale beats are emitted.

## Test plan
- Delay-line core model (out = in delayed CORE_LAT), single block with s_data[i] = 8r+i for row r, m_ready=1 -> beat c has m_data[i] = 8i+c; m_last only on beat 7; first m_valid at cycle 25.
- Three blocks with s_valid held high -> 24 beats in block/column order. s_ready is low exactly in the cycles with a column issue. Blocks complete 16 cycles apart in steady state.
- m_ready=0 after block 0 is issued -> column issue stops when fifo_count + in-flight = 16. No data is lost. Releasing m_ready yields all beats in order.
- Blocks 1 and 2 offered while the output is stalled -> rows of block 2 are held off (s_ready=0) until a buffer frees. Output is correct afterwards.
- rst_n pulsed low during the column drain of block 0 -> all outputs take reset values immediately. No beat appears from block 0; a new block sent afterwards produces the exact expected output.
- Real 1D core, all 64 inputs = 64 -> only beat 0 m_data[0] is nonzero. All beats match the bit-true 2D model.

Source files
------------

// File: rtl/dct_2d_sched.sv
// 8x8 2D DCT scheduler around one shared 8-point 1D core.
// Rows pass through the core into a ping-pong transpose buffer; columns are re-issued and streamed out.
module dct_2d_sched #(
    parameter int W          = 16,
    parameter int CORE_LAT   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0][W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0][W-1:0] m_data,
    output logic              m_last,
    output logic [7:0][W-1:0] core_x_in,
    input  logic [7:0][W-1:0] core_x_out,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {B_EMPTY, B_FILLING, B_WAIT_ROWS, B_FULL, B_DRAINING} buf_st_e;

    typedef struct packed {
        logic       vld;
        logic       is_col;
        logic       bid;
        logic [2:0] idx;
        logic       last;
    } tag_t;

    buf_st_e           st_q [2];
    buf_st_e           st_d [2];
    logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [2:0]        row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
    logic [2:0]        land_cnt_q [2];
    logic [2:0]        land_cnt_d [2];
    tag_t              tag_q [CORE_LAT];
    tag_t              tag_d [CORE_LAT];
    logic [CW-1:0]     infl_q, infl_d, fcnt_q, fcnt_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0][W-1:0] tbuf_q [2][8];
    logic [8*W:0]      fifo_q [FIFO_DEPTH];

    tag_t              tag_out;
    logic              row_land, col_land, col_issue, row_issue, row_elig, pop, tags_live;
    logic [7:0][W-1:0] col_word;

    assign m_valid           = (fcnt_q != '0);
    assign {m_last, m_data}  = m_valid ? fifo_q[rptr_q] : '0;
    assign pop               = m_valid && m_ready;

    always_comb begin
        tag_out   = tag_q[CORE_LAT-1];
        row_land  = tag_out.vld && !tag_out.is_col;
        col_land  = tag_out.vld && tag_out.is_col;
        // credit includes in-flight columns so a landing column always has a FIFO slot
        col_issue = (st_q[rd_sel_q] == B_FULL || st_q[rd_sel_q] == B_DRAINING) &&
                    (({1'b0, fcnt_q} + {1'b0, infl_q}) < DEPTH);
        row_elig  = (st_q[wr_sel_q] == B_EMPTY) || (st_q[wr_sel_q] == B_FILLING);
        s_ready   = row_elig && !col_issue;
        row_issue = s_valid && s_ready;

        for (int k = 0; k < 8; k++) col_word[k] = tbuf_q[rd_sel_q][k][col_cnt_q];
        core_x_in = col_issue ? col_word : (row_issue ? s_data : '0);

        for (int b = 0; b < 2; b++) begin
            st_d[b]       = st_q[b];
            land_cnt_d[b] = land_cnt_q[b];
        end
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;

        if (row_issue) begin
            st_d[wr_sel_q] = B_FILLING;
            row_cnt_d      = row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) begin
                st_d[wr_sel_q] = B_WAIT_ROWS;
                wr_sel_d       = !wr_sel_q;
            end
        end
        if (col_issue) begin
            st_d[rd_sel_q] = B_DRAINING;
            col_cnt_d      = col_cnt_q + 3'd1;
            if (col_cnt_q == 3'd7) begin
                st_d[rd_sel_q] = B_EMPTY;
                rd_sel_d       = !rd_sel_q;
            end
        end
        // landing counter wraps to 0 on the 8th row, ready for the next block
        if (row_land) begin
            land_cnt_d[tag_out.bid] = land_cnt_q[tag_out.bid] + 3'd1;
            if (land_cnt_q[tag_out.bid] == 3'd7) st_d[tag_out.bid] = B_FULL;
        end

        tag_d[0].vld    = row_issue || col_issue;
        tag_d[0].is_col = col_issue;
        tag_d[0].bid    = col_issue ? rd_sel_q : wr_sel_q;
        tag_d[0].idx    = col_issue ? col_cnt_q : row_cnt_q;
        tag_d[0].last   = col_issue && (col_cnt_q == 3'd7);
        for (int i = 1; i < CORE_LAT; i++) tag_d[i] = tag_q[i-1];

        infl_d = infl_q + CW'(col_issue) - CW'(col_land);
        fcnt_d = fcnt_q + CW'(col_land) - CW'(pop);
        wptr_d = col_land ? ((wptr_q == PTR_MAX) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop ? ((rptr_q == PTR_MAX) ? '0 : rptr_q + 1'b1) : rptr_q;

        tags_live = 1'b0;
        for (int i = 0; i < CORE_LAT; i++) tags_live = tags_live | tag_q[i].vld;
        busy = (st_q[0] != B_EMPTY) || (st_q[1] != B_EMPTY) || tags_live || (fcnt_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]       <= B_EMPTY;
                land_cnt_q[b] <= '0;
            end
            for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            infl_q    <= '0;
            fcnt_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]       <= st_d[b];
                land_cnt_q[b] <= land_cnt_d[b];
            end
            for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= tag_d[i];
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            infl_q    <= infl_d;
            fcnt_q    <= fcnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked entirely by state and tags.
    always_ff @(posedge clk) begin
        if (row_land) tbuf_q[tag_out.bid][tag_out.idx] <= core_x_out;
        if (col_land) fifo_q[wptr_q] <= {tag_out.last, core_x_out};
    end
endmodule

// File: tb/tb_dct_2d_sched.sv
// Directed bench for dct_2d_sched with a delay-line or integer-DCT core model.
module tb_dct_2d_sched;
    localparam int W = 16, CORE_LAT = 8, FIFO_DEPTH = 16;

    logic              clk = 0, rst_n = 0, s_valid = 0, m_ready = 1;
    logic              s_ready, m_valid, m_last, busy;
    logic [7:0][W-1:0] s_data = '0, m_data, core_x_in, core_x_out;
    logic [7:0][W-1:0] pipe [CORE_LAT];
    logic              core_mode = 0, saw_hold = 0;
    int                cyc = 0, n_cmp = 0, n_err = 0, first_acc = -1, first_v = -1;
    logic [8*W:0]      obs_q[$], exp_q[$];

    dct_2d_sched #(.W(W), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_x_in(core_x_in), .core_x_out(core_x_out), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ct(input int m);
        case (m)
            0: return 2048; 1: return 2009; 2: return 1892; 3: return 1703;
            4: return 1448; 5: return 1138; 6: return 784;  7: return 400;
            default: return 0;
        endcase
    endfunction

    function automatic int coef(input int k, input int n);
        int m;
        if (k == 0) return 1448;
        m = ((2*n + 1) * k) % 32;
        if (m <= 8)  return ct(m);
        if (m <= 16) return -ct(16 - m);
        if (m <= 24) return -ct(m - 16);
        return ct(32 - m);
    endfunction

    // Q12 orthonormal 8-point DCT, round-half-up then truncate to W
    function automatic logic [7:0][W-1:0] dct1d(input logic [7:0][W-1:0] x);
        logic [7:0][W-1:0]   y;
        logic signed [W-1:0] xs;
        longint              acc;
        for (int k = 0; k < 8; k++) begin
            acc = 2048;
            for (int n = 0; n < 8; n++) begin
                xs = x[n];
                acc += longint'(coef(k, n)) * longint'(xs);
            end
            y[k] = W'(acc >>> 12);
        end
        return y;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= core_mode ? dct1d(core_x_in) : core_x_in;
        for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_x_out = pipe[CORE_LAT-1];

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            obs_q.push_back({m_last, m_data});
            if (first_v < 0) first_v = cyc;
        end
        if (s_valid && !s_ready) saw_hold = 1;
    end

    task automatic chk(input string tag, input logic [8*W:0] got, input logic [8*W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rv(input int pat, input int b, input int r, input int i);
        case (pat)
            0:       return W'(100*b + 8*r + i);
            1:       return W'(64);
            default: return W'((8*r + i) * 9 - 200);
        endcase
    endfunction

    task automatic push_exp(input int pat, input int b);
        logic [7:0][W-1:0] y [8];
        logic [7:0][W-1:0] v;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) v[i] = rv(pat, b, r, i);
            y[r] = core_mode ? dct1d(v) : v;
        end
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) v[k] = y[k][c];
            if (core_mode) v = dct1d(v);
            exp_q.push_back({(c == 7), v});
        end
    endtask

    task automatic send_blocks(input int pat, input int b0, input int n);
        int guard;
        for (int b = b0; b < b0 + n; b++) begin
            push_exp(pat, b);
            for (int r = 0; r < 8; r++) begin
                guard = 0;
                do begin
                    @(negedge clk);
                    s_valid = 1;
                    for (int i = 0; i < 8; i++) s_data[i] = rv(pat, b, r, i);
                    guard++;
                end while (!s_ready && guard < 2000);
                if (!s_ready) begin
                    chk("send_timeout", 0, 1);
                    s_valid = 0;
                    return;
                end
                if (first_acc < 0) first_acc = cyc;
            end
        end
        @(negedge clk);
        s_valid = 0;
        s_data  = '0;
    endtask

    task automatic wait_beats(input int n);
        int g = 0;
        while (obs_q.size() < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic cmp_clear(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [8*W:0] t;
        int nz, g;

        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_core_x_in", core_x_in, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);

        // single block through the delay-line core
        first_acc = -1; first_v = -1;
        send_blocks(0, 0, 1);
        wait_beats(8);
        chk("latency", first_v - first_acc, 25);
        if (obs_q.size() >= 8) begin
            t = obs_q[3]; chk("hand_b3w5", t[5*W +: W], 43);
            t = obs_q[0]; chk("hand_b0w7", t[7*W +: W], 56);
            t = obs_q[7]; chk("hand_last7", t[8*W], 1);
            t = obs_q[6]; chk("hand_last6", t[8*W], 0);
        end
        cmp_clear("single");

        // three back-to-back blocks
        send_blocks(0, 1, 3);
        wait_beats(24);
        cmp_clear("b2b");

        // output stall with three blocks offered
        m_ready = 0; saw_hold = 0;
        send_blocks(0, 4, 3);
        repeat (30) @(negedge clk);
        nz = 0;
        repeat (10) begin
            @(negedge clk);
            if (core_x_in != '0) nz++;
        end
        chk("stall_no_issue", nz, 0);
        chk("stall_hold", saw_hold, 1);
        chk("stall_valid", m_valid, 1);
        chk("stall_busy", busy, 1);
        chk("stall_head", {m_last, m_data}, exp_q[0]);
        chk("stall_nopop", obs_q.size(), 0);
        m_ready = 1;
        wait_beats(24);
        cmp_clear("stall");

        // reset in the middle of the column drain
        first_acc = -1;
        send_blocks(0, 7, 1);
        g = 0;
        while (cyc < first_acc + 19 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("pre_rst_issue", (core_x_in != '0), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_core_x_in", core_x_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        repeat (40) @(negedge clk);
        chk("rst_no_stale", obs_q.size(), 0);
        obs_q.delete();
        send_blocks(0, 8, 1);
        wait_beats(8);
        cmp_clear("post_rst");

        // integer DCT core
        core_mode = 1;
        repeat (12) @(negedge clk);
        send_blocks(1, 9, 1);
        wait_beats(8);
        if (obs_q.size() >= 8) begin
            t = obs_q[0]; chk("dc_b0w0", t[W-1:0], 512);
            chk("dc_b0_rest", t[8*W-1:W], 0);
            t = obs_q[4]; chk("dc_b4", t[8*W-1:0], 0);
        end
        cmp_clear("dct_dc");
        send_blocks(2, 10, 1);
        wait_beats(8);
        cmp_clear("dct_ramp");
        chk("idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
